// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C configuration sequencer: FSM states, table
// entry layout and the end-of-table marker address.
package i2c_pkg;

  localparam int ENTRY_W = 23;
  localparam logic [6:0] END_ADDR = 7'h7F;

  localparam int ADDR_HI = 22;
  localparam int ADDR_LO = 16;
  localparam int SUB_HI  = 15;
  localparam int SUB_LO  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5,
    ST_RECOVER   = 3'd6,
    ST_FINISH    = 3'd7
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable saturating down-counter with a zero flag; one instance serves the
// handshake timeout, the recovery pulse length and the inter-transfer gap.
module i2c_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a register table and issues one I2C write per entry via a master.
// Optional inter-transfer idle gap enabled by defining I2C_CFG_SEQ_GAP_EN.
module i2c_cfg_sequencer
  import i2c_pkg::*;
#(
  parameter int N_ENTRIES      = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 100,
  localparam int IDX_W         = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [IDX_W-1:0]   tbl_idx,
  input  logic [ENTRY_W-1:0] tbl_entry,
  output logic               m_start,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_sub,
  output logic [7:0]         m_data,
  input  logic               m_ready,
  output logic               m_reset
);

  localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  seq_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_error, w_error_nxt;
  logic             r_start, w_start_nxt;
  logic             r_mreset, w_mreset_nxt;
  logic [6:0]       r_addr;
  logic [7:0]       r_sub;
  logic [7:0]       r_data;
  logic             w_latch;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_last;
  logic [6:0]       w_entry_addr;

  assign w_last       = (r_idx == IDX_W'(N_ENTRIES - 1));
  assign w_entry_addr = tbl_entry[ADDR_HI:ADDR_LO];

  i2c_seq_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = r_error;
    w_start_nxt  = 1'b0;
    w_mreset_nxt = 1'b0;
    w_latch      = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = TO_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt = ST_FETCH;
          w_idx_nxt   = '0;
          w_error_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_latch = 1'b1;
        if (w_entry_addr == END_ADDR) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_state_nxt = ST_ISSUE;
          w_tmr_load  = 1'b1;
        end
      end
      ST_ISSUE: begin
        // A ready master wins over an expiring timer so start never meets m_reset.
        if (m_ready) begin
          w_start_nxt = 1'b1;
          w_state_nxt = ST_WAIT_BUSY;
          w_tmr_load  = 1'b1;
        end else if (w_tmr_zero) begin
          w_state_nxt  = ST_RECOVER;
          w_mreset_nxt = 1'b1;
          w_error_nxt  = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_val    = REC_LOAD;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT_BUSY: begin
        if (!m_ready) begin
          w_state_nxt = ST_WAIT_DONE;
          w_tmr_load  = 1'b1;
        end else if (w_tmr_zero) begin
          w_state_nxt  = ST_RECOVER;
          w_mreset_nxt = 1'b1;
          w_error_nxt  = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_val    = REC_LOAD;
        end else begin
          w_state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (m_ready) begin
`ifdef I2C_CFG_SEQ_GAP_EN
          w_state_nxt = ST_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = GAP_LOAD;
`else
          if (w_last) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_FETCH;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end
`endif
        end else if (w_tmr_zero) begin
          w_state_nxt  = ST_RECOVER;
          w_mreset_nxt = 1'b1;
          w_error_nxt  = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_val    = REC_LOAD;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
`ifdef I2C_CFG_SEQ_GAP_EN
      ST_GAP: begin
        if (!w_tmr_zero) begin
          w_state_nxt = ST_GAP;
        end else if (w_last) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_state_nxt = ST_FETCH;
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
`endif
      ST_RECOVER: begin
        // Timer was loaded with 1, so m_reset stays up for exactly two cycles.
        if (w_tmr_zero) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_mreset_nxt = 1'b1;
        end
      end
      ST_FINISH: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_start  <= 1'b0;
      r_mreset <= 1'b0;
      r_addr   <= 7'd0;
      r_sub    <= 8'd0;
      r_data   <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
      r_start  <= w_start_nxt;
      r_mreset <= w_mreset_nxt;
      if (w_latch) begin
        r_addr <= tbl_entry[ADDR_HI:ADDR_LO];
        r_sub  <= tbl_entry[SUB_HI:SUB_LO];
        r_data <= tbl_entry[DATA_HI:DATA_LO];
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign tbl_idx = r_idx;
  assign m_start = r_start;
  assign m_reset = r_mreset;
  assign m_addr  = r_addr;
  assign m_sub   = r_sub;
  assign m_data  = r_data;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Self-checking bench for i2c_cfg_sequencer: table-driven scenarios plus
// hand-written timing sequences; a behavioural master answers each start.
module tb_i2c_cfg_sequencer;
  import i2c_pkg::*;

  localparam int N   = 16;
  localparam int TO  = 64;
  localparam int GAP = 10;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          reset, go, m_ready;
  logic          busy, done, error, m_start, m_reset;
  logic [IW-1:0] tbl_idx;
  logic [22:0]   tbl_entry;
  logic [6:0]    m_addr;
  logic [7:0]    m_sub, m_data;
  logic [22:0]   tbl [N];

  int total = 0, bad = 0, cyc = 0;
  int starts = 0, mres_cycles = 0, busy_cycles = 0, done_seen = 0;
  int done_cyc = 0, start_cyc = 0, mres_first_cyc = 0, rise_cyc = 0, gap_last = 0;
  int overlap = 0, go_cyc = 0, rdy_cnt = 0;
  logic stuck = 1'b0, prev_rdy = 1'b1;

  typedef struct {
    int   n_valid;
    logic stuck;
    int   exp_starts;
    logic exp_err;
    int   exp_idx;
    int   exp_mres;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tbl_entry = tbl[tbl_idx];

  i2c_cfg_sequencer #(.N_ENTRIES(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done), .error(error),
    .tbl_idx(tbl_idx), .tbl_entry(tbl_entry), .m_start(m_start), .m_addr(m_addr),
    .m_sub(m_sub), .m_data(m_data), .m_ready(m_ready), .m_reset(m_reset)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int n_valid);
    for (int i = 0; i < N; i++) begin
      if (i < n_valid) tbl[i] = {7'(16 + i), 8'(32 + i), 8'(160 + i)};
      else             tbl[i] = {END_ADDR, 8'h00, 8'h00};
    end
  endtask

  task automatic start_go();
    starts = 0; mres_cycles = 0; busy_cycles = 0; done_seen = 0;
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
    check("error_cleared_on_go", int'(error), 0);
    check("busy_after_go", int'(busy), 1);
  endtask

  task automatic run_go(input int max_cyc);
    int n;
    start_go();
    n = 0;
    while (done_seen == 0 && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_pulses", done_seen, 1);
  endtask

  // Negedge monitor: counts pulses and checks issued fields against the table.
  initial begin
    forever begin
      @(negedge clk);
      if (m_start) begin
        if (starts > 0) gap_last = cyc - rise_cyc;
        if (starts < N) check("start_fields", int'({m_addr, m_sub, m_data}), int'(tbl[starts]));
        start_cyc = cyc;
        starts++;
      end
      if (m_reset) begin
        if (mres_cycles == 0) mres_first_cyc = cyc;
        mres_cycles++;
      end
      if (m_start && m_reset) overlap++;
      if (busy) busy_cycles++;
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (m_ready && !prev_rdy) rise_cyc = cyc;
      prev_rdy = m_ready;
    end
  end

  // Master model: m_ready drops after each start and returns 30 cycles later.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (m_start) begin
        m_ready = 1'b0;
        rdy_cnt = stuck ? 0 : 30;
      end else if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) m_ready = 1'b1;
      end
    end
  end

  initial begin
    int n;
    vec_t v;
    vecs[0] = '{0,  1'b0, 0,  1'b0, 0,  0};
    vecs[1] = '{2,  1'b0, 2,  1'b0, 2,  0};
    vecs[2] = '{16, 1'b0, 16, 1'b0, 15, 0};
    vecs[3] = '{5,  1'b1, 1,  1'b1, 0,  2};
    vecs[4] = '{3,  1'b0, 3,  1'b0, 3,  0};

    fill(0);
    reset = 1'b1; go = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done_err", int'({done, error}), 0);
    check("rst_start_mreset", int'({m_start, m_reset}), 0);
    check("rst_idx", int'(tbl_idx), 0);
    check("rst_fields", int'({m_addr, m_sub, m_data}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      fill(v.n_valid);
      stuck = v.stuck; m_ready = 1'b1; rdy_cnt = 0;
      run_go(2000);
      check("vec_starts", starts, v.exp_starts);
      check("vec_error", int'(error), int'(v.exp_err));
      check("vec_idx", int'(tbl_idx), v.exp_idx);
      check("vec_mreset_cycles", mres_cycles, v.exp_mres);
      check("vec_busy_end", int'(busy), 0);
      stuck = 1'b0; m_ready = 1'b1; rdy_cnt = 0;
      repeat (3) @(negedge clk);
    end

    // End marker in entry 0: done three cycles after go, busy for two.
    fill(0);
    run_go(50);
    check("marker_done_latency", done_cyc - go_cyc, 3);
    check("marker_busy_cycles", busy_cycles, 2);
    check("marker_starts", starts, 0);

    // Reference two-write table.
    tbl[0] = {7'h68, 8'h20, 8'h0F};
    tbl[1] = {7'h68, 8'h23, 8'h80};
    tbl[2] = {7'h7F, 8'h00, 8'h00};
    run_go(500);
    check("ref_starts", starts, 2);
    check("ref_error", int'(error), 0);
`ifdef I2C_CFG_SEQ_GAP_EN
    check("gap_spacing_ge10", int'(gap_last >= 10), 1);
`else
    check("ready_to_start", gap_last, 3);
`endif

    // Master stuck busy: timeout, two-cycle m_reset, error, then done.
    repeat (3) @(negedge clk);
    fill(3);
    stuck = 1'b1;
    run_go(500);
    check("timeout_delay", mres_first_cyc - start_cyc, 65);
    check("timeout_mreset_cycles", mres_cycles, 2);
    check("timeout_error", int'(error), 1);
    check("timeout_done_after_reset", done_cyc - mres_first_cyc, 3);
    stuck = 1'b0; m_ready = 1'b1; rdy_cnt = 0;
    repeat (3) @(negedge clk);

    // Reset during the second transfer's WAIT_DONE, with go held in that cycle.
    fill(3);
    start_go();
    n = 0;
    while (starts < 2 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_mid_second_start", starts, 2);
    repeat (5) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("go_ignored_busy_idx", int'(tbl_idx), 1);
    check("go_ignored_busy", int'(busy), 1);
    reset = 1'b1; go = 1'b1;
    @(negedge clk);
    reset = 1'b0; go = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_start", int'(m_start), 0);
    check("rst_mid_idx", int'(tbl_idx), 0);
    @(negedge clk);
    check("go_in_reset_ignored", int'(busy), 0);
    repeat (40) @(negedge clk);

    check("start_reset_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
